ula_pipe: RTL

Parametrised, registered successor to the MIC-1 combinational ULA. It combines the 6-bit MIC-1 function select (F0 F1 ENA ENB INVA INC) with the MIC-1 output shifter (SLL8, SRA1) and a one-entry output register behind a valid/ready handshake. An iterative multiply can optionally be compiled in. It sits between the B-bus/H register and the C-bus in the datapath and lets the controller stall on backpressure.

---
 rtl/ula_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ula_pipe.sv
// Registered MIC-1 ALU + output shifter behind a valid/ready handshake.
// Define ULA_MUL_EN to add the iterative shift-add multiply (select 100000).
module ula_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       select,
    input  logic [1:0]       shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             N,
    output logic             Z,
    output logic             ill
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef ULA_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic             n_q;
    logic             z_q;
    logic             ill_q;

    logic [WIDTH-1:0] aluRes_d;
    logic             selIll_d;
    logic             accept;

    function automatic logic [WIDTH-1:0] applyShift(input logic [WIDTH-1:0] x,
                                                    input logic [1:0]       s);
        case (s)
            2'b10:   return x << 8;
            2'b01:   return {x[WIDTH-1], x[WIDTH-1:1]};
            default: return x;
        endcase
    endfunction

    always_comb begin
        aluRes_d = '0;
        selIll_d = 1'b0;
        case (select)
            6'b011000: aluRes_d = A;
            6'b010100: aluRes_d = B;
            6'b011010: aluRes_d = ~A;
            6'b101100: aluRes_d = ~B;
            6'b111100: aluRes_d = A + B;
            6'b111101: aluRes_d = A + B + ONE;
            6'b111001: aluRes_d = A + ONE;
            6'b110101: aluRes_d = B + ONE;
            6'b111111: aluRes_d = B - A;
            6'b110110: aluRes_d = B - ONE;
            6'b111011: aluRes_d = ~A + ONE;
            6'b001100: aluRes_d = A & B;
            6'b011100: aluRes_d = A | B;
            6'b010000: aluRes_d = '0;
            6'b110001: aluRes_d = ONE;
            6'b110010: aluRes_d = '1;
`ifdef ULA_MUL_EN
            6'b100000: aluRes_d = '0;
`endif
            default:   selIll_d = 1'b1;
        endcase
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign ill       = ill_q;

`ifdef ULA_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       mulShift_q;
    logic [WIDTH-1:0] accNext_d;
    logic             isMul;

    assign isMul     = (select == 6'b100000);
    assign accNext_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    // Accept path is shared by IDLE and DONE so a retiring result and a new
    // command can cross on the same edge without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            out_q      <= '0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            ill_q      <= 1'b0;
`ifdef ULA_MUL_EN
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mulShift_q <= 2'b00;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ULA_MUL_EN
                        if (isMul) begin
                            state_q    <= BUSY;
                            acc_q      <= '0;
                            mcand_q    <= A;
                            mplier_q   <= B;
                            cnt_q      <= CNT_INIT;
                            mulShift_q <= shift;
                        end else
`endif
                        begin
                            state_q <= DONE;
                            out_q   <= applyShift(aluRes_d, shift);
                            n_q     <= aluRes_d[WIDTH-1];
                            z_q     <= (aluRes_d == '0);
                            ill_q   <= selIll_d || (shift == 2'b11);
                        end
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
`ifdef ULA_MUL_EN
                // One multiplier bit per cycle; the last iteration writes the
                // product straight into the output register.
                BUSY: begin
                    acc_q    <= accNext_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        out_q   <= applyShift(accNext_d, mulShift_q);
                        n_q     <= accNext_d[WIDTH-1];
                        z_q     <= (accNext_d == '0);
                        ill_q   <= (mulShift_q == 2'b11);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
